// File: rtl/apb2_hall_capture.sv
// -----------------------------------------------------------------------------
// apb2_hall_capture
//
// Multi-channel hall-sensor commutation capture with an APB2 slave interface.
// For each motor channel the three raw hall bits are synchronised, optionally
// glitch-filtered, and tracked against the forward sequence 1,3,2,6,4,5,1.
// Each accepted step updates a signed position counter, the direction and the
// measured commutation period. Illegal patterns bump a saturating error count.
// A saturating period timer flags a stalled motor.
//
// Optional feature:
//   HALL_CAPTURE_FILTER_EN - when defined, a synchronised hall state is only
//   taken after 4 identical consecutive samples, which adds 3 cycles of latency.
//
// Ports:
//   pclk          clock for all logic
//   prst          synchronous active-high reset
//   psel/penable  APB2 select / access phase
//   pwrite        APB2 write
//   paddr[7:0]    APB2 byte address
//   pwdata[31:0]  APB2 write data
//   pstrb[3:0]    byte strobes (ignored, full-word writes only)
//   prdata[31:0]  read data, driven while psel=1, else 0
//   pready        always 1 (zero wait states)
//   pslverr       error for unmapped addresses in the access phase
//   hall_values   raw hall inputs, channel n on bits [3n+2:3n]
//   detected_dir  per channel 2 bits: 01 forward, 10 reverse, 00 stopped
//   irq           OR of (IRQ_STATUS & IRQ_EN)
//
// Register map (channel n at 16n): +0 STATUS, +4 PERIOD, +8 POSITION,
// +C ERR_COUNT; 0xF0 IRQ_EN, 0xF4 IRQ_STATUS (W1C).
// -----------------------------------------------------------------------------
module apb2_hall_capture #(
  parameter int CHANNELS    = 2,
  parameter int TIMER_WIDTH = 24,
  parameter int POS_WIDTH   = 16
) (
  input  logic                    pclk,
  input  logic                    prst,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [7:0]              paddr,
  input  logic [31:0]             pwdata,
  input  logic [3:0]              pstrb,
  output logic [31:0]             prdata,
  output logic                    pready,
  output logic                    pslverr,
  input  logic [3*CHANNELS-1:0]   hall_values,
  output logic [2*CHANNELS-1:0]   detected_dir,
  output logic                    irq
);

  localparam int IRQ_W = 2 * CHANNELS;
  localparam logic [TIMER_WIDTH-1:0] TIMER_MAX = {TIMER_WIDTH{1'b1}};
  localparam logic [TIMER_WIDTH-1:0] TIMER_PRE = TIMER_MAX - TIMER_WIDTH'(1);

  typedef logic signed [POS_WIDTH-1:0] pos_t;

  // Successor of a hall state in the forward sequence; 0 for invalid states.
  function automatic logic [2:0] fwd_next(input logic [2:0] s);
    logic [2:0] n;
    case (s)
      3'd1:    n = 3'd3;
      3'd3:    n = 3'd2;
      3'd2:    n = 3'd6;
      3'd6:    n = 3'd4;
      3'd4:    n = 3'd5;
      3'd5:    n = 3'd1;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

  function automatic logic hall_valid(input logic [2:0] s);
    return (s != 3'd0) && (s != 3'd7);
  endfunction

  // Per-channel state
  logic [2:0]             sync1_q  [CHANNELS];
  logic [2:0]             sync2_q  [CHANNELS];
  logic [2:0]             obs_q    [CHANNELS];  // last observed (post-filter) state
  logic [2:0]             acc_q    [CHANNELS];  // last accepted valid state
  logic [2:0]             acc_d    [CHANNELS];
  logic [1:0]             dir_q    [CHANNELS];
  logic [1:0]             dir_d    [CHANNELS];
  logic [TIMER_WIDTH-1:0] timer_q  [CHANNELS];
  logic [TIMER_WIDTH-1:0] timer_d  [CHANNELS];
  logic [31:0]            period_q [CHANNELS];
  logic [31:0]            period_d [CHANNELS];
  pos_t                   pos_q    [CHANNELS];
  pos_t                   pos_d    [CHANNELS];
  logic [7:0]             errcnt_q [CHANNELS];
  logic [7:0]             errcnt_d [CHANNELS];
  logic [CHANNELS-1:0]    stall_q;
  logic [CHANNELS-1:0]    stall_d;
`ifdef HALL_CAPTURE_FILTER_EN
  logic [2:0]             cand_q   [CHANNELS];
  logic [1:0]             fcnt_q   [CHANNELS];
`endif

  logic [IRQ_W-1:0]       irq_en_q;
  logic [IRQ_W-1:0]       irq_en_d;
  logic [IRQ_W-1:0]       irq_st_q;
  logic [IRQ_W-1:0]       irq_st_d;
  logic                   irq_q;

  // Per-channel event decode
  logic [2:0]             cur_s    [CHANNELS];
  logic [CHANNELS-1:0]    chg_s;
  logic [CHANNELS-1:0]    vld_s;
  logic [CHANNELS-1:0]    fwd_s;
  logic [CHANNELS-1:0]    rev_s;
  logic [CHANNELS-1:0]    err_s;
  logic [CHANNELS-1:0]    stall_evt_s;

  // APB decode
  logic [CHANNELS-1:0]    ch_hit_s;
  logic                   en_hit_s;
  logic                   st_hit_s;
  logic                   addr_ok_s;
  logic                   wr_s;
  logic [31:0]            rdata_s;
  logic                   unused_s;

  assign unused_s = ^{pstrb, pwdata, paddr[1:0]};

  // Address decode and APB handshake outputs.
  always_comb begin
    ch_hit_s = {CHANNELS{1'b0}};
    for (int n = 0; n < CHANNELS; n++) begin
      ch_hit_s[n] = (paddr[7:4] == 4'(n));
    end
    en_hit_s  = (paddr[7:2] == 6'h3C);
    st_hit_s  = (paddr[7:2] == 6'h3D);
    addr_ok_s = (|ch_hit_s) | en_hit_s | st_hit_s;
    wr_s      = psel & penable & pwrite & addr_ok_s;
    pslverr   = psel & penable & ~addr_ok_s;
    pready    = 1'b1;
  end

  // Classify each change of the observed hall state as acquisition, step or error.
  always_comb begin
    chg_s       = {CHANNELS{1'b0}};
    vld_s       = {CHANNELS{1'b0}};
    fwd_s       = {CHANNELS{1'b0}};
    rev_s       = {CHANNELS{1'b0}};
    err_s       = {CHANNELS{1'b0}};
    stall_evt_s = {CHANNELS{1'b0}};
    for (int n = 0; n < CHANNELS; n++) begin
`ifdef HALL_CAPTURE_FILTER_EN
      // fcnt_q==2 with a matching sample means this is the 4th identical sample.
      if ((sync2_q[n] == cand_q[n]) && (fcnt_q[n] >= 2'd2)) begin
        cur_s[n] = sync2_q[n];
      end else begin
        cur_s[n] = obs_q[n];
      end
`else
      cur_s[n] = sync2_q[n];
`endif
      chg_s[n] = (cur_s[n] != obs_q[n]);
      vld_s[n] = hall_valid(cur_s[n]);
      fwd_s[n] = chg_s[n] & vld_s[n] & (acc_q[n] != 3'd0) & (cur_s[n] == fwd_next(acc_q[n]));
      rev_s[n] = chg_s[n] & vld_s[n] & (acc_q[n] != 3'd0) & (fwd_next(cur_s[n]) == acc_q[n]);
      // Returning to the accepted state after an invalid glitch is not an error.
      err_s[n] = chg_s[n] & (~vld_s[n] | ((acc_q[n] != 3'd0) & (cur_s[n] != acc_q[n])
                                          & ~fwd_s[n] & ~rev_s[n]));
      stall_evt_s[n] = ~(fwd_s[n] | rev_s[n]) & (timer_q[n] == TIMER_PRE);
    end
  end

  // Next-state for channel registers and interrupt registers; hardware events win over software.
  always_comb begin
    if (wr_s && en_hit_s) begin
      irq_en_d = pwdata[IRQ_W-1:0];
    end else begin
      irq_en_d = irq_en_q;
    end
    if (wr_s && st_hit_s) begin
      irq_st_d = irq_st_q & ~pwdata[IRQ_W-1:0];
    end else begin
      irq_st_d = irq_st_q;
    end
    stall_d = stall_q;
    for (int n = 0; n < CHANNELS; n++) begin
      if (chg_s[n] && vld_s[n]) begin
        acc_d[n] = cur_s[n];
      end else begin
        acc_d[n] = acc_q[n];
      end

      if (fwd_s[n] || rev_s[n]) begin
        timer_d[n]  = {TIMER_WIDTH{1'b0}};
        period_d[n] = 32'(timer_q[n]) + 32'd1;
        stall_d[n]  = 1'b0;
      end else begin
        timer_d[n]  = (timer_q[n] == TIMER_MAX) ? TIMER_MAX : timer_q[n] + TIMER_WIDTH'(1);
        period_d[n] = period_q[n];
        if (stall_evt_s[n]) begin
          stall_d[n] = 1'b1;
        end else begin
          stall_d[n] = stall_q[n];
        end
      end

      if (fwd_s[n]) begin
        dir_d[n] = 2'b01;
      end else if (rev_s[n]) begin
        dir_d[n] = 2'b10;
      end else if (stall_evt_s[n]) begin
        dir_d[n] = 2'b00;
      end else begin
        dir_d[n] = dir_q[n];
      end

      // A step on the same cycle as a software load applies on top of the loaded value.
      if (wr_s && ch_hit_s[n] && (paddr[3:2] == 2'd2)) begin
        pos_d[n] = pos_t'(pwdata[POS_WIDTH-1:0]);
      end else begin
        pos_d[n] = pos_q[n];
      end
      if (fwd_s[n]) begin
        pos_d[n] = pos_d[n] + pos_t'(1);
      end else if (rev_s[n]) begin
        pos_d[n] = pos_d[n] - pos_t'(1);
      end else begin
        pos_d[n] = pos_d[n];
      end

      if (wr_s && ch_hit_s[n] && (paddr[3:2] == 2'd3)) begin
        errcnt_d[n] = 8'd0;
      end else begin
        errcnt_d[n] = errcnt_q[n];
      end
      if (err_s[n]) begin
        errcnt_d[n] = (errcnt_d[n] == 8'hFF) ? 8'hFF : errcnt_d[n] + 8'd1;
      end else begin
        errcnt_d[n] = errcnt_d[n];
      end

      if (err_s[n]) begin
        irq_st_d[2*n] = 1'b1;
      end else begin
        irq_st_d[2*n] = irq_st_d[2*n];
      end
      if (stall_evt_s[n]) begin
        irq_st_d[2*n+1] = 1'b1;
      end else begin
        irq_st_d[2*n+1] = irq_st_d[2*n+1];
      end
    end
  end

  // State registers, synchronisers and optional glitch filter.
  always_ff @(posedge pclk) begin
    if (prst) begin
      for (int n = 0; n < CHANNELS; n++) begin
        sync1_q[n]  <= 3'd0;
        sync2_q[n]  <= 3'd0;
        obs_q[n]    <= 3'd0;
        acc_q[n]    <= 3'd0;
        dir_q[n]    <= 2'b00;
        timer_q[n]  <= {TIMER_WIDTH{1'b0}};
        period_q[n] <= 32'd0;
        pos_q[n]    <= pos_t'(0);
        errcnt_q[n] <= 8'd0;
`ifdef HALL_CAPTURE_FILTER_EN
        cand_q[n]   <= 3'd0;
        fcnt_q[n]   <= 2'd0;
`endif
      end
      stall_q  <= {CHANNELS{1'b0}};
      irq_en_q <= {IRQ_W{1'b0}};
      irq_st_q <= {IRQ_W{1'b0}};
      irq_q    <= 1'b0;
    end else begin
      for (int n = 0; n < CHANNELS; n++) begin
        sync1_q[n]  <= hall_values[3*n +: 3];
        sync2_q[n]  <= sync1_q[n];
        obs_q[n]    <= cur_s[n];
        acc_q[n]    <= acc_d[n];
        dir_q[n]    <= dir_d[n];
        timer_q[n]  <= timer_d[n];
        period_q[n] <= period_d[n];
        pos_q[n]    <= pos_d[n];
        errcnt_q[n] <= errcnt_d[n];
`ifdef HALL_CAPTURE_FILTER_EN
        if (sync2_q[n] == cand_q[n]) begin
          if (fcnt_q[n] != 2'd3) begin
            fcnt_q[n] <= fcnt_q[n] + 2'd1;
          end else begin
            fcnt_q[n] <= fcnt_q[n];
          end
        end else begin
          cand_q[n] <= sync2_q[n];
          fcnt_q[n] <= 2'd0;
        end
`endif
      end
      stall_q  <= stall_d;
      irq_en_q <= irq_en_d;
      irq_st_q <= irq_st_d;
      // Built from next-state values so irq tracks the registers without extra lag.
      irq_q    <= |(irq_st_d & irq_en_d);
    end
  end

  // Read mux: data only while selected, zero for unmapped addresses.
  always_comb begin
    rdata_s = 32'd0;
    if (psel) begin
      for (int n = 0; n < CHANNELS; n++) begin
        if (ch_hit_s[n]) begin
          case (paddr[3:2])
            2'd0:    rdata_s = {23'd0, stall_q[n], (errcnt_q[n] != 8'd0), 1'b0,
                                dir_q[n], 1'b0, acc_q[n]};
            2'd1:    rdata_s = period_q[n];
            2'd2:    rdata_s = 32'(pos_q[n]);
            2'd3:    rdata_s = {24'd0, errcnt_q[n]};
            default: rdata_s = 32'd0;
          endcase
        end else begin
          rdata_s = rdata_s;
        end
      end
      if (en_hit_s) begin
        rdata_s[IRQ_W-1:0] = irq_en_q;
      end else if (st_hit_s) begin
        rdata_s[IRQ_W-1:0] = irq_st_q;
      end else begin
        rdata_s = rdata_s;
      end
    end else begin
      rdata_s = 32'd0;
    end
  end

  // Output mapping of registered direction and read data.
  always_comb begin
    detected_dir = {IRQ_W{1'b0}};
    for (int n = 0; n < CHANNELS; n++) begin
      detected_dir[2*n +: 2] = dir_q[n];
    end
    prdata = rdata_s;
    irq    = irq_q;
  end

endmodule
